// File: rtl/in_pass_sync_filter.sv
// in_pass_sync_filter: per-channel IO input pass (comb / registered / 2-flop sync / debounce).
// Debounce filter is built only with INPASS_DEBOUNCE_EN; otherwise mode 11 aliases mode 10.
module in_pass_sync_filter #(
  parameter int NUM_CH        = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  UserCLK,
  input  logic                  RESETn,
  input  logic [NUM_CH-1:0]     I,
  output logic [NUM_CH-1:0]     O,
  input  logic [2*NUM_CH-1:0]   ConfigBits
);
  if (NUM_CH < 1 || FILTER_CYCLES < 2) begin : g_param_check
    $error("in_pass_sync_filter: NUM_CH must be >= 1 and FILTER_CYCLES >= 2");
  end
  logic [NUM_CH-1:0] q1, q2, filt;
  always_ff @(posedge UserCLK) begin
    if (!RESETn) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= I;
      q2 <= q1;
    end
  end
`ifdef INPASS_DEBOUNCE_EN
  localparam int CW = $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    // a disagreement must persist FILTER_CYCLES samples of q2 before the level flips
    always_ff @(posedge UserCLK) begin
      if (!RESETn) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (q2[n] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl <= q2[n];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign filt[n] = lvl;
  end
`else
  assign filt = q2;
`endif
  always_comb begin
    O = '0;
    for (int k = 0; k < NUM_CH; k++)
      O[k] = ConfigBits[2*k+1] ? (ConfigBits[2*k] ? filt[k] : q2[k])
                               : (ConfigBits[2*k] ? q1[k] : I[k]);
  end
endmodule
